rst_pipe: RTL

Parametrised valid/data pipeline with per-stage backpressure. It is the successor to the fixed-depth rst_all/rst_bad/rst_good comparison blocks. Only control state (valid bits, occupancy) is reset; data registers are reset only when the configuration macro is set. It sits between any valid/ready producer and consumer as a DEPTH-cycle register slice with bubble collapsing, synchronous flush and an occupancy count.

---
 rtl/rst_pkg.sv | 22 ++
 rtl/rst_pipe_stage.sv | 60 ++++++
 rtl/rst_pipe.sv | 88 ++++++++
 3 files changed

// File: rtl/rst_pkg.sv
// Shared definitions for the reset-style block family (rst_all, rst_bad,
// rst_good, rst_pipe) and their benches: default widths and a constant
// log2 helper for sizing counters.
package rst_pkg;

    localparam int RST_DW_DEF    = 4;
    localparam int RST_DEPTH_DEF = 3;

    // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 32'sd0;
        rem    = value - 32'sd1;
        while (rem > 32'sd0) begin
            result = result + 32'sd1;
            rem    = rem >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rst_pipe_stage.sv
// One register slice of rst_pipe: a valid bit plus a data word.
// The stage loads whenever it is empty or its downstream neighbour loads,
// so bubbles are always overwritten.
// Configuration macro: RST_PIPE_DATA_RST_EN -- when defined the data word
// is asynchronously reset to zero; otherwise the data flop has no reset.
module rst_pipe_stage
    import rst_pkg::*;
#(
    parameter int DW = RST_DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          ld_next_s,
    input  logic          v_prev_s,
    input  logic [DW-1:0] d_prev_s,
    output logic          ld_s,
    output logic          v_r,
    output logic [DW-1:0] d_r
);

    // A stage may take new content if it holds nothing or its content moves on.
    assign ld_s = ~v_r | ld_next_s;

    // Valid bit: cleared by reset and flush, otherwise follows upstream on load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_r <= 1'b0;
        end else if (flush_i) begin
            v_r <= 1'b0;
        end else if (ld_s) begin
            v_r <= v_prev_s;
        end else begin
            v_r <= v_r;
        end
    end

`ifdef RST_PIPE_DATA_RST_EN
    // Data word with reset: loaded only when a valid word arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_r <= {DW{1'b0}};
        end else if (!flush_i && ld_s && v_prev_s) begin
            d_r <= d_prev_s;
        end else begin
            d_r <= d_r;
        end
    end
`else
    // Data word without reset: loaded only when a valid word arrives.
    always_ff @(posedge clk) begin
        if (!flush_i && ld_s && v_prev_s) begin
            d_r <= d_prev_s;
        end else begin
            d_r <= d_r;
        end
    end
`endif

endmodule

// File: rtl/rst_pipe.sv
// rst_pipe: DEPTH-stage valid/ready register pipeline with bubble
// collapsing, synchronous flush and an occupancy count.
// Only control state is reset by default; define RST_PIPE_DATA_RST_EN to
// also reset the data registers (see rst_pipe_stage).
// ready_o is a combinational chain from ready_i through the stage loads.
module rst_pipe
    import rst_pkg::*;
#(
    parameter  int DW    = RST_DW_DEF,
    parameter  int DEPTH = RST_DEPTH_DEF,
    localparam int CW    = clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [DW-1:0] data_o,
    output logic [CW-1:0] count_o
);

    logic in_s;
    logic out_s;

    // Stage 0 is the input side, stage DEPTH-1 drives the outputs.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic          ld_next_s;
        logic          v_prev_s;
        logic [DW-1:0] d_prev_s;
        logic          ld_s;
        logic          v_r;
        logic [DW-1:0] d_r;

        if (k == DEPTH - 1) begin : g_last
            assign ld_next_s = ready_i;
        end else begin : g_mid
            assign ld_next_s = g_stage[k+1].ld_s;
        end

        if (k == 0) begin : g_first
            assign v_prev_s = valid_i;
            assign d_prev_s = data_i;
        end else begin : g_inner
            assign v_prev_s = g_stage[k-1].v_r;
            assign d_prev_s = g_stage[k-1].d_r;
        end

        rst_pipe_stage #(
            .DW (DW)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .flush_i   (flush_i),
            .ld_next_s (ld_next_s),
            .v_prev_s  (v_prev_s),
            .d_prev_s  (d_prev_s),
            .ld_s      (ld_s),
            .v_r       (v_r),
            .d_r       (d_r)
        );
    end

    assign ready_o = g_stage[0].ld_s & ~flush_i;
    assign valid_o = g_stage[DEPTH-1].v_r;
    assign data_o  = g_stage[DEPTH-1].d_r;

    assign in_s  = valid_i & ready_o;
    assign out_s = valid_o & ready_i;

    // Occupancy: +1 per input transfer, -1 per output transfer, zero on flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_o <= {CW{1'b0}};
        end else if (flush_i) begin
            count_o <= {CW{1'b0}};
        end else begin
            case ({in_s, out_s})
                2'b10:   count_o <= count_o + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_o <= count_o - {{(CW-1){1'b0}}, 1'b1};
                default: count_o <= count_o;
            endcase
        end
    end

endmodule
